// File: rtl/csi_sync_fifo.sv
// csi_sync_fifo: parametrised single-clock FIFO between the CSI protocol
// layer (byte producer) and the D-PHY adapter (byte consumer).
// Provides a registered occupancy count, almost-full/almost-empty
// watermarks and sticky overflow/underflow error flags.
// Optional feature macro: CSI_FIFO_FWFT_EN
//   defined   -> first-word-fall-through output (head word always visible)
//   undefined -> registered read (popped word appears one edge after pop)
module csi_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  input  logic                         ValidRx,
  input  logic [DATA_WIDTH-1:0]        DataRx,
  output logic                         FullRx,
  output logic                         AlmostFullRx,
  input  logic                         ReadyTx,
  output logic [DATA_WIDTH-1:0]        DataTx,
  output logic                         ValidTx,
  output logic                         EmptyTx,
  output logic                         AlmostEmptyTx,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  input  logic                         ClearErr,
  output logic                         OverflowErr,
  output logic                         UnderflowErr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] AE_LEVEL   = LW'(AE_MARGIN);
  localparam logic [LW-1:0] ZERO_LEVEL = '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [LW-1:0]         levelNext;
  logic                  push;
  logic                  pop;

  // Full/empty come from the registered level, so a same-cycle pop never
  // opens room for a write into a full FIFO.
  assign FullRx  = (Level == FULL_LEVEL);
  assign EmptyTx = (Level == ZERO_LEVEL);
  assign push    = ValidRx && !FullRx;
  assign pop     = ReadyTx && !EmptyTx;

  // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
  always_comb begin
    levelNext = Level;
    if (push && !pop) begin
      levelNext = Level + LW'(1);
    end else if (pop && !push) begin
      levelNext = Level - LW'(1);
    end
  end

  // Storage write; contents need no reset because the level makes them invisible.
  always_ff @(posedge Clk) begin
    if (ResetN && push) begin
      mem[wrPtr] <= DataRx;
    end
  end

  // Pointers, level, watermarks and sticky error flags.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      Level         <= '0;
      AlmostFullRx  <= (ZERO_LEVEL >= AF_LEVEL);
      AlmostEmptyTx <= (ZERO_LEVEL <= AE_LEVEL);
      OverflowErr   <= 1'b0;
      UnderflowErr  <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
      end
      Level         <= levelNext;
      AlmostFullRx  <= (levelNext >= AF_LEVEL);
      AlmostEmptyTx <= (levelNext <= AE_LEVEL);
      OverflowErr   <= (ValidRx && FullRx) || (OverflowErr && !ClearErr);
      UnderflowErr  <= (ReadyTx && EmptyTx) || (UnderflowErr && !ClearErr);
    end
  end

`ifdef CSI_FIFO_FWFT_EN
  // Head word falls through; masked to zero while empty so stale storage never shows.
  always_comb begin
    ValidTx = !EmptyTx;
    DataTx  = EmptyTx ? '0 : mem[rdPtr];
  end
`else
  // Registered read: a pop loads the head word and flags it valid for one cycle.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      DataTx  <= '0;
      ValidTx <= 1'b0;
    end else if (pop) begin
      DataTx  <= mem[rdPtr];
      ValidTx <= 1'b1;
    end else begin
      ValidTx <= 1'b0;
    end
  end
`endif

endmodule
